bsg_1_to_n_tagged_buffered: RTL and testbench

Tagged fan-out stage with per-channel storage. Accepts one `{tag, data}` word per cycle on a ready/valid input and enqueues it into a small FIFO selected by the tag. Each FIFO drains independently on its own valid/yumi output, so one stalled consumer never blocks words bound for other channels unless that channel's FIFO is full. It sits in the same place as the combinational tagged demux, for consumers that need data carried and decoupled rather than a bare valid fan-out.

---
 rtl/bsg_1_to_n_tagged_pkg.sv | 14 +
 rtl/bsg_tagged_chan_fifo.sv | 65 ++++++
 rtl/bsg_1_to_n_tagged_buffered.sv | 82 ++++++++
 tb/tb_bsg_1_to_n_tagged_buffered.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_1_to_n_tagged_pkg.sv
// Shared constants and helpers for the tagged buffered fan-out.
//   stall_cnt_width_gp : width of the input-stall counter
//   stall_cnt_max_gp   : saturation value of the input-stall counter
//   tag_width_f        : tag width for a given channel count (minimum 1)
package bsg_1_to_n_tagged_pkg;

  localparam int unsigned stall_cnt_width_gp = 16;
  localparam logic [stall_cnt_width_gp-1:0] stall_cnt_max_gp = 16'hFFFF;

  function automatic int unsigned tag_width_f(input int unsigned num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

// File: rtl/bsg_tagged_chan_fifo.sv
// One channel's circular FIFO: storage, read/write pointers and occupancy count.
//   clk_i, reset_i : clock, synchronous active-high reset
//   enq_i, data_i  : write a word at the tail (caller guarantees ~full_o)
//   full_o         : count == els_p
//   v_o, data_o    : head valid / head word
//   yumi_i         : pop the head; ignored while empty
module bsg_tagged_chan_fifo
  import bsg_1_to_n_tagged_pkg::*;
#(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] els_cnt_lp  = cnt_w_lp'(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wr_ptr;
  logic [ptr_w_lp-1:0] r_rd_ptr;
  logic [cnt_w_lp-1:0] r_cnt;

  logic w_enq;
  logic w_deq;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign w_enq  = enq_i & ~full_o;
  assign w_deq  = yumi_i & v_o;
  assign full_o = (r_cnt == els_cnt_lp);
  assign v_o    = (r_cnt != '0);
  assign data_o = r_mem[r_rd_ptr];

  // Pointers and count; enq+deq together leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_deq) r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_enq & ~w_deq)      r_cnt <= r_cnt + cnt_w_lp'(1);
      else if (~w_enq & w_deq) r_cnt <= r_cnt - cnt_w_lp'(1);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (~reset_i & w_enq) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bsg_1_to_n_tagged_buffered.sv
// Tagged fan-out with a small FIFO per output channel.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   v_i, tag_i, data_i : input word; accepted when v_i & ready_o
//   ready_o            : addressed channel in range and not full (no path from yumi_i)
//   v_o, data_o        : per-channel head valid / flattened head data
//   yumi_i             : per-channel dequeue
//   stall_cnt_o        : saturating count of stalled input cycles when
//                        BSG_1_TO_N_TAGGED_BUFFERED_STALL_CNT_EN is defined, else 0
module bsg_1_to_n_tagged_buffered
  import bsg_1_to_n_tagged_pkg::*;
#(
  parameter  int unsigned num_out_p    = 32,
  parameter  int unsigned width_p      = 32,
  parameter  int unsigned els_p        = 2,
  localparam int unsigned tag_width_lp = tag_width_f(num_out_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [tag_width_lp-1:0]       tag_i,
  input  logic [width_p-1:0]            data_i,
  output logic                          ready_o,
  output logic [num_out_p-1:0]          v_o,
  output logic [num_out_p*width_p-1:0]  data_o,
  input  logic [num_out_p-1:0]          yumi_i,
  output logic [stall_cnt_width_gp-1:0] stall_cnt_o
);

  localparam logic [tag_width_lp:0] num_out_lp = (tag_width_lp + 1)'(num_out_p);

  logic [num_out_p-1:0] w_full;
  logic [num_out_p-1:0] w_enq;
  logic                 w_full_sel;
  logic                 w_tag_in_range;

  // Select the addressed channel's full flag; out-of-range tags read as full.
  always_comb begin
    w_tag_in_range = ({1'b0, tag_i} < num_out_lp);
    w_full_sel     = 1'b1;
    for (int k = 0; k < int'(num_out_p); k++) begin
      if (tag_i == tag_width_lp'(k)) w_full_sel = w_full[k];
    end
  end

  assign ready_o = ~reset_i & w_tag_in_range & ~w_full_sel;

  for (genvar k = 0; k < int'(num_out_p); k++) begin : g_chan
    assign w_enq[k] = v_i & ready_o & (tag_i == tag_width_lp'(k));

    bsg_tagged_chan_fifo #(
      .width_p (width_p),
      .els_p   (els_p)
    ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .enq_i   (w_enq[k]),
      .data_i  (data_i),
      .full_o  (w_full[k]),
      .v_o     (v_o[k]),
      .data_o  (data_o[k*width_p +: width_p]),
      .yumi_i  (yumi_i[k])
    );
  end

`ifdef BSG_1_TO_N_TAGGED_BUFFERED_STALL_CNT_EN
  logic [stall_cnt_width_gp-1:0] r_stall_cnt;

  // Count cycles where a valid word is refused; sticks at the max value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_stall_cnt <= '0;
    end else if (v_i & ~ready_o & (r_stall_cnt != stall_cnt_max_gp)) begin
      r_stall_cnt <= r_stall_cnt + stall_cnt_width_gp'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_1_to_n_tagged_buffered.sv
module tb_bsg_1_to_n_tagged_buffered;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int E  = 2;
  localparam int N2 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (defaults)
  logic            reset_i, v_i, ready_o;
  logic [4:0]      tag_i;
  logic [W-1:0]    data_i;
  logic [N-1:0]    yumi_i, v_o;
  logic [N*W-1:0]  data_o;
  logic [15:0]     stall_cnt_o;

  // second DUT with a non-power-of-two channel count
  logic            v2, ready2;
  logic [4:0]      tag2;
  logic [W-1:0]    data2;
  logic [N2-1:0]   yumi2, v_o2;
  logic [N2*W-1:0] data_o2;
  logic [15:0]     stall2;

  bsg_1_to_n_tagged_buffered #(.num_out_p(N), .width_p(W), .els_p(E)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .tag_i(tag_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .stall_cnt_o(stall_cnt_o)
  );

  bsg_1_to_n_tagged_buffered #(.num_out_p(N2), .width_p(W), .els_p(E)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v2), .tag_i(tag2), .data_i(data2),
    .ready_o(ready2), .v_o(v_o2), .data_o(data_o2), .yumi_i(yumi2),
    .stall_cnt_o(stall2)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one queue per channel plus a stall count
  logic [W-1:0] mq [N][$];
  int unsigned  m_stall;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Check main DUT against the model, then advance one clock and update the model.
  task automatic cycle();
    logic         er;
    logic [N-1:0] ev;
    #1;
    er = !reset_i && (mq[tag_i].size() < E);
    chk("ready_o", ready_o, er);
    ev = '0;
    for (int k = 0; k < N; k++) if (mq[k].size() > 0) ev[k] = 1'b1;
    chk("v_o", v_o, ev);
    for (int k = 0; k < N; k++)
      if (mq[k].size() > 0) chk($sformatf("data_o[%0d]", k), data_o[k*W +: W], mq[k][0]);
    chk("stall_cnt_o", stall_cnt_o, m_stall);
    @(posedge clk);
    if (reset_i) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      m_stall = 0;
    end else begin
`ifdef BSG_1_TO_N_TAGGED_BUFFERED_STALL_CNT_EN
      if (v_i && !er && m_stall != 32'hFFFF) m_stall++;
`endif
      for (int k = 0; k < N; k++)
        if (yumi_i[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      if (v_i && er) mq[tag_i].push_back(data_i);
    end
    @(negedge clk);
  endtask

  initial begin
    m_stall = 0;
    reset_i = 1'b1; v_i = 1'b1; tag_i = 5'd5; data_i = '0; yumi_i = '0;
    v2 = 1'b0; tag2 = '0; data2 = '0; yumi2 = '0;
    @(posedge clk);
    @(negedge clk);

    // reset with v_i=1, tag 5
    repeat (3) cycle();
    reset_i = 1'b0; v_i = 1'b0;
    #1 chk("idle_ready", ready_o, 1'b1);
    chk("idle_v", v_o, '0);
    cycle();

    // basic routing to channel 3
    v_i = 1'b1; tag_i = 5'd3; data_i = 32'hA5A5_0003;
    cycle();
    v_i = 1'b0;
    #1 chk("route_v", v_o, 32'h0000_0008);
    chk("route_data", data_o[3*W +: W], 32'hA5A5_0003);
    yumi_i[3] = 1'b1;
    cycle();
    yumi_i = '0;
    #1 chk("route_pop_v", v_o, '0);

    // backpressure isolation: fill channel 7, channel 8 still accepts
    v_i = 1'b1; tag_i = 5'd7; data_i = 32'h0007_0000;
    cycle();
    data_i = 32'h0007_0001;
    cycle();
    data_i = 32'h0007_0002;
    #1 chk("bp_ready7", ready_o, 1'b0);
    cycle();
    tag_i = 5'd8; data_i = 32'h0008_0000;
    #1 chk("bp_ready8", ready_o, 1'b1);
    cycle();
    v_i = 1'b0;
    #1 chk("bp_v8", v_o[8], 1'b1);
    chk("bp_head7", data_o[7*W +: W], 32'h0007_0000);

    // simultaneous enq/deq on channel 1 holding one word
    v_i = 1'b1; tag_i = 5'd1; data_i = 32'd0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      data_i = 32'(i + 1); yumi_i = 32'h2;
      #1 chk("sim_head", data_o[1*W +: W], 32'(i));
      chk("sim_v", v_o[1], 1'b1);
      cycle();
    end
    v_i = 1'b0; yumi_i = '1;
    repeat (3) cycle();
    yumi_i = '0;

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      v_i     = ($urandom_range(0, 3) != 0);
      tag_i   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      data_i  = $urandom;
      yumi_i  = $urandom & $urandom;
      reset_i = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset_i = 1'b0; v_i = 1'b0; yumi_i = '0;
    cycle();

    // second DUT: out-of-range tag and yumi on an empty channel
    v2 = 1'b1; tag2 = 5'd25; data2 = 32'hDEAD_BEEF;
    #1 chk("d2_oor_ready", ready2, 1'b0);
    cycle();
    v2 = 1'b0;
    #1 chk("d2_oor_v", v_o2, '0);
`ifdef BSG_1_TO_N_TAGGED_BUFFERED_STALL_CNT_EN
    chk("d2_stall", stall2, 16'd1);
`else
    chk("d2_stall", stall2, 16'd0);
`endif
    yumi2 = 20'h10;
    cycle();
    yumi2 = '0;
    #1 chk("d2_empty_yumi_v", v_o2, '0);
    v2 = 1'b1; tag2 = 5'd4; data2 = 32'h0000_4444;
    #1 chk("d2_ready4", ready2, 1'b1);
    cycle();
    data2 = 32'h0000_4445;
    cycle();
    v2 = 1'b0;
    #1 chk("d2_v4", v_o2, 20'h00010);
    chk("d2_data4", data_o2[4*W +: W], 32'h0000_4444);
    chk("d2_full4", ready2, 1'b0);
    yumi2 = 20'h10;
    cycle();
    #1 chk("d2_data4b", data_o2[4*W +: W], 32'h0000_4445);
    cycle();
    yumi2 = '0;
    #1 chk("d2_drained", v_o2, '0);

`ifdef BSG_1_TO_N_TAGGED_BUFFERED_STALL_CNT_EN
    // saturate the stall counter against a full channel 0
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0; v_i = 1'b1; tag_i = 5'd0;
    cycle();
    cycle();
    repeat (65600) @(posedge clk);
    @(negedge clk);
    #1 chk("stall_sat", stall_cnt_o, 16'hFFFF);
    m_stall = 32'hFFFF;
    cycle();
    v_i = 1'b0;
`endif
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
